// File: rtl/bypass_ctrl_if.sv
// Decode <-> bypass controller bundle: operand/destination info from decode, bypass selects and stall back.
// Perf counter fields read as zero unless the controller is built with BYPASS_PERF_CNT_EN.
interface bypass_ctrl_if #(
    parameter int ADDR_SIZE = 5
);
    logic                 D_valid;
    logic [ADDR_SIZE-1:0] D_ra;
    logic [ADDR_SIZE-1:0] D_rb;
    logic                 D_use_ra;
    logic                 D_use_rb;
    logic [ADDR_SIZE-1:0] D_rd;
    logic                 D_we;
    logic                 D_ld;
    logic                 F_flush;
    logic                 MEM_stall;
    logic [1:0]           EX_D_bp;
    logic [1:0]           MEM_D_bp;
    logic [1:0]           WB_D_bp;
    logic                 D_stall;
    logic [31:0]          perf_stall_cnt;
    logic [31:0]          perf_bp_cnt;

    modport master (
        output D_valid, D_ra, D_rb, D_use_ra, D_use_rb, D_rd, D_we, D_ld, F_flush, MEM_stall,
        input  EX_D_bp, MEM_D_bp, WB_D_bp, D_stall, perf_stall_cnt, perf_bp_cnt
    );

    modport slave (
        input  D_valid, D_ra, D_rb, D_use_ra, D_use_rb, D_rd, D_we, D_ld, F_flush, MEM_stall,
        output EX_D_bp, MEM_D_bp, WB_D_bp, D_stall, perf_stall_cnt, perf_bp_cnt
    );
endinterface

// File: rtl/bypass_ctrl.sv
// Purpose: tracks in-flight writes in EX/MEM/WB shadow slots, drives decode bypass selects, stalls on load-use.
// Latency: 0 cycles, bypass selects and D_stall are combinational from the slots and D_* inputs.
// Backpressure: MEM_stall freezes every slot and raises D_stall; optional counters under BYPASS_PERF_CNT_EN.
module bypass_ctrl #(
    parameter int ADDR_SIZE = 5
) (
    input  logic          clk,
    input  logic          rst,
    bypass_ctrl_if.slave  bus
);

    typedef struct packed {
        logic                 v;
        logic                 we;
        logic [ADDR_SIZE-1:0] rd;
    } slot_t;

    slot_t ex_slot;
    slot_t mem_slot;
    slot_t wb_slot;
    logic  ex_ld;

    logic [1:0] ex_hit;
    logic [1:0] mem_hit;
    logic [1:0] wb_hit;
    logic [1:0] load_use_bits;
    logic       load_use;

    function automatic logic slot_hit(slot_t s, logic [ADDR_SIZE-1:0] idx, logic use_x);
        return s.v && s.we && (s.rd != '0) && (s.rd == idx) && use_x;
    endfunction

    always_comb begin
        ex_hit  = {slot_hit(ex_slot,  bus.D_ra, bus.D_use_ra), slot_hit(ex_slot,  bus.D_rb, bus.D_use_rb)};
        mem_hit = {slot_hit(mem_slot, bus.D_ra, bus.D_use_ra), slot_hit(mem_slot, bus.D_rb, bus.D_use_rb)};
        wb_hit  = {slot_hit(wb_slot,  bus.D_ra, bus.D_use_ra), slot_hit(wb_slot,  bus.D_rb, bus.D_use_rb)};
        ex_hit  = ex_hit  & {2{bus.D_valid}};
        mem_hit = mem_hit & {2{bus.D_valid}};
        wb_hit  = wb_hit  & {2{bus.D_valid}};
    end

    // A load in EX owns the operand even though its data is not ready: older stages must not backfill.
    assign load_use_bits = ex_hit & {2{ex_ld}};
    assign load_use      = |load_use_bits;

    assign bus.EX_D_bp  = ex_hit & ~{2{ex_ld}};
    assign bus.MEM_D_bp = mem_hit & ~ex_hit;
    assign bus.WB_D_bp  = wb_hit & ~ex_hit & ~mem_hit;
    assign bus.D_stall  = load_use | bus.MEM_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_slot  <= '0;
            mem_slot <= '0;
            wb_slot  <= '0;
            ex_ld    <= 1'b0;
        end else if (!bus.MEM_stall) begin
            wb_slot  <= mem_slot;
            mem_slot <= ex_slot;
            if (bus.D_valid && !load_use && !bus.F_flush) begin
                ex_slot <= '{v: 1'b1, we: bus.D_we, rd: bus.D_rd};
                ex_ld   <= bus.D_ld;
            end else begin
                ex_slot <= '0;
                ex_ld   <= 1'b0;
            end
        end
    end

`ifdef BYPASS_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] bp_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            bp_cnt    <= '0;
        end else begin
            if (load_use)
                stall_cnt <= stall_cnt + 32'd1;
            if (|{bus.EX_D_bp, bus.MEM_D_bp, bus.WB_D_bp})
                bp_cnt <= bp_cnt + 32'd1;
        end
    end

    assign bus.perf_stall_cnt = stall_cnt;
    assign bus.perf_bp_cnt    = bp_cnt;
`else
    assign bus.perf_stall_cnt = '0;
    assign bus.perf_bp_cnt    = '0;
`endif

endmodule
